// File: rtl/bram_rr_arbiter_if.sv
// Bundle of the signals between bram_rr_arbiter, its two requesters and the
// single-port block memory.
// Ports: requester side  req0/1, we0/1, addr0/1, wdata0/1 -> arbiter
//                        ack0/1, rvalid0/1, rdata0/1      <- arbiter
//        memory side     wea, addra, dina <- arbiter; douta -> arbiter
//        status          busy <- arbiter
// slave  : the arbiter's view (consumes requests and douta, drives the rest).
// master : the environment's view (requesters plus the memory).
interface bram_rr_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  // requester 0
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  // requester 1
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  // memory port
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  // status
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  douta,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1,
    output wea, addra, dina,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output douta,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1,
    input  wea, addra, dina,
    input  busy
  );

endinterface

// File: rtl/bram_rr_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port block memory.
// Latency: ack one cycle after the request is sampled; read data RD_LAT+2
//   cycles after the request is sampled; write occupies the port for 2 cycles.
// Backpressure: requests wait (held by the requester) until ack; requests are
//   only sampled while idle, so at most one command is in flight.
//
// Ports:
//   clka  - clock, all state on the rising edge
//   rsta  - synchronous active-high reset
//   bus   - bram_rr_arbiter_if.slave: requester handshakes, read return
//           paths, the memory port (wea/addra/dina/douta) and busy.
// Parameters: ADDR_W, DATA_W must match the interface instance; RD_LAT is
//   the memory read latency (1..3 cycles).
// Build option: define BRAM_ARB_FIXED_PRI_EN for fixed priority (requester 0
//   always wins a conflict); otherwise arbitration is round-robin.
module bram_rr_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clka,
  input  logic                  rsta,
  bram_rr_arbiter_if.slave      bus
);

  // 2 bits cover the legal latency range 1..3
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t            state, state_nxt;
  logic              wea_r, wea_nxt;
  logic [ADDR_W-1:0] addra_r, addra_nxt;
  logic [DATA_W-1:0] dina_r, dina_nxt;
  logic              ack0_r, ack0_nxt;
  logic              ack1_r, ack1_nxt;
  logic              rvalid0_r, rvalid0_nxt;
  logic              rvalid1_r, rvalid1_nxt;
  logic [DATA_W-1:0] rdata0_r, rdata0_nxt;
  logic [DATA_W-1:0] rdata1_r, rdata1_nxt;
  logic              owner, owner_nxt;     // 0/1: requester owning the command
  logic [CNT_W-1:0]  cnt, cnt_nxt;         // remaining read-latency cycles
  logic              pick1;                // requester 1 wins in IDLE

`ifndef BRAM_ARB_FIXED_PRI_EN
  logic              last, last_nxt;       // requester granted most recently
`endif

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef BRAM_ARB_FIXED_PRI_EN
  // requester 1 only gets the port when requester 0 is silent
  assign pick1 = bus.req1 & ~bus.req0;
`else
  // on a conflict the requester not granted last wins
  assign pick1 = bus.req1 & (~bus.req0 | ~last);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    wea_nxt     = wea_r;
    addra_nxt   = addra_r;
    dina_nxt    = dina_r;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    rdata0_nxt  = rdata0_r;
    rdata1_nxt  = rdata1_r;
    owner_nxt   = owner;
    cnt_nxt     = cnt;
`ifndef BRAM_ARB_FIXED_PRI_EN
    last_nxt    = last;
`endif

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = CMD;
          owner_nxt = pick1;
`ifndef BRAM_ARB_FIXED_PRI_EN
          last_nxt  = pick1;
`endif
          if (pick1) begin
            wea_nxt   = bus.we1;
            addra_nxt = bus.addr1;
            dina_nxt  = bus.wdata1;
            ack1_nxt  = 1'b1;
          end else begin
            wea_nxt   = bus.we0;
            addra_nxt = bus.addr0;
            dina_nxt  = bus.wdata0;
            ack0_nxt  = 1'b1;
          end
        end
      end

      CMD: begin
        // command is on the port this cycle; wea_r still carries its type
        wea_nxt = 1'b0;
        if (wea_r) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(RD_LAT);
        end
      end

      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        // cnt==1 is the cycle in which douta carries the result
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          if (owner) begin
            rdata1_nxt  = bus.douta;
            rvalid1_nxt = 1'b1;
          end else begin
            rdata0_nxt  = bus.douta;
            rvalid0_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        wea_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= IDLE;
      wea_r     <= 1'b0;
      addra_r   <= '0;
      dina_r    <= '0;
      ack0_r    <= 1'b0;
      ack1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
      owner     <= 1'b0;
      cnt       <= '0;
`ifndef BRAM_ARB_FIXED_PRI_EN
      // "1 granted last" so requester 0 wins the first conflict
      last      <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      wea_r     <= wea_nxt;
      addra_r   <= addra_nxt;
      dina_r    <= dina_nxt;
      ack0_r    <= ack0_nxt;
      ack1_r    <= ack1_nxt;
      rvalid0_r <= rvalid0_nxt;
      rvalid1_r <= rvalid1_nxt;
      rdata0_r  <= rdata0_nxt;
      rdata1_r  <= rdata1_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
`ifndef BRAM_ARB_FIXED_PRI_EN
      last      <= last_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.wea     = wea_r;
  assign bus.addra   = addra_r;
  assign bus.dina    = dina_r;
  assign bus.ack0    = ack0_r;
  assign bus.ack1    = ack1_r;
  assign bus.rvalid0 = rvalid0_r;
  assign bus.rvalid1 = rvalid1_r;
  assign bus.rdata0  = rdata0_r;
  assign bus.rdata1  = rdata1_r;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_bram_rr_arbiter.sv
module tb_bram_rr_arbiter;

  logic clka = 1'b0;
  logic rsta = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clka = ~clka;

  bram_rr_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b1 ();
  bram_rr_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b2 ();

  bram_rr_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1)) dut1 (
    .clka (clka),
    .rsta (rsta),
    .bus  (b1)
  );

  bram_rr_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(2)) dut2 (
    .clka (clka),
    .rsta (rsta),
    .bus  (b2)
  );

  // Behavioural single-port memories: read-first, RD_LAT register stages.
  logic [15:0] mem1 [1024];
  logic [15:0] mem2 [1024];
  logic [15:0] p1, p2a, p2b;

  always @(posedge clka) begin
    if (b1.wea) mem1[b1.addra] <= b1.dina;
    p1 <= mem1[b1.addra];
  end

  always @(posedge clka) begin
    if (b2.wea) mem2[b2.addra] <= b2.dina;
    p2a <= mem2[b2.addra];
    p2b <= p2a;
  end

  assign b1.douta = p1;
  assign b2.douta = p2b;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle_inputs();
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = '0; b1.wdata0 = '0;
    b1.req1 = 0; b1.we1 = 0; b1.addr1 = '0; b1.wdata1 = '0;
    b2.req0 = 0; b2.we0 = 0; b2.addr0 = '0; b2.wdata0 = '0;
    b2.req1 = 0; b2.we1 = 0; b2.addr1 = '0; b2.wdata1 = '0;
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    tick();
    tick();
    rsta = 1'b0;
  endtask

  // Stimulus only: write through requester 1 of dut1 while it is idle.
  task automatic preload1(input logic [9:0] a, input logic [15:0] d);
    b1.req1 = 1; b1.we1 = 1; b1.addr1 = a; b1.wdata1 = d;
    tick();
    b1.req1 = 0; b1.we1 = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1} !== 4'b0) begin n_err++;
      $display("FAIL reset_handshake got %b want 0000", {b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1}); end
    n_cmp++; if ({b1.wea, b1.addra, b1.dina} !== 27'h0) begin n_err++;
      $display("FAIL reset_memport got %h want 0", {b1.wea, b1.addra, b1.dina}); end
    n_cmp++; if ({b1.rdata0, b1.rdata1} !== 32'h0) begin n_err++;
      $display("FAIL reset_rdata got %h want 0", {b1.rdata0, b1.rdata1}); end
    n_cmp++; if (b1.busy !== 1'b0 || b2.busy !== 1'b0) begin n_err++;
      $display("FAIL reset_busy got %b%b want 00", b1.busy, b2.busy); end
  endtask

  task automatic test_single_write();
    b1.req0 = 1; b1.we0 = 1; b1.addr0 = 10'h001; b1.wdata0 = 16'hBEEF;
    tick();  // k+1
    n_cmp++; if (b1.ack0 !== 1'b1 || b1.wea !== 1'b1) begin n_err++;
      $display("FAIL wr_ack_wea got ack0=%b wea=%b want 1 1", b1.ack0, b1.wea); end
    n_cmp++; if (b1.addra !== 10'h001 || b1.dina !== 16'hBEEF) begin n_err++;
      $display("FAIL wr_addr_data got %h/%h want 001/beef", b1.addra, b1.dina); end
    n_cmp++; if (b1.busy !== 1'b1) begin n_err++;
      $display("FAIL wr_busy got %b want 1", b1.busy); end
    b1.req0 = 0; b1.we0 = 0;
    tick();  // k+2
    n_cmp++; if (b1.wea !== 1'b0 || b1.ack0 !== 1'b0 || b1.busy !== 1'b0) begin n_err++;
      $display("FAIL wr_done got wea=%b ack0=%b busy=%b want 0 0 0", b1.wea, b1.ack0, b1.busy); end
  endtask

  task automatic test_read_back();
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 10'h001;
    tick();  // k+1
    n_cmp++; if (b1.ack0 !== 1'b1 || b1.wea !== 1'b0) begin n_err++;
      $display("FAIL rd_ack got ack0=%b wea=%b want 1 0", b1.ack0, b1.wea); end
    b1.req0 = 0;
    tick();  // k+2
    n_cmp++; if (b1.rvalid0 !== 1'b0 || b1.busy !== 1'b1) begin n_err++;
      $display("FAIL rd_wait got rvalid0=%b busy=%b want 0 1", b1.rvalid0, b1.busy); end
    tick();  // k+3
    n_cmp++; if (b1.rvalid0 !== 1'b1 || b1.rdata0 !== 16'hBEEF) begin n_err++;
      $display("FAIL rd_data got rvalid0=%b rdata0=%h want 1 beef", b1.rvalid0, b1.rdata0); end
    n_cmp++; if (b1.rdata1 !== 16'h0 || b1.rvalid1 !== 1'b0 || b1.busy !== 1'b0) begin n_err++;
      $display("FAIL rd_other got rdata1=%h rvalid1=%b busy=%b want 0 0 0", b1.rdata1, b1.rvalid1, b1.busy); end
    tick();  // k+4
    n_cmp++; if (b1.rvalid0 !== 1'b0 || b1.rdata0 !== 16'hBEEF) begin n_err++;
      $display("FAIL rd_hold got rvalid0=%b rdata0=%h want 0 beef", b1.rvalid0, b1.rdata0); end
  endtask

  task automatic test_conflict();
    int a0, a1, v0, v1;
    logic [15:0] d0, d1;
    a0 = -1; a1 = -1; v0 = -1; v1 = -1; d0 = '0; d1 = '0;
    preload1(10'h002, 16'h1234);
    do_reset();
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 10'h001;
    b1.req1 = 1; b1.we1 = 0; b1.addr1 = 10'h002;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (b1.ack0 === 1'b1 && a0 < 0) begin a0 = c; b1.req0 = 0; end
      if (b1.ack1 === 1'b1 && a1 < 0) begin a1 = c; b1.req1 = 0; end
      if (b1.rvalid0 === 1'b1 && v0 < 0) begin v0 = c; d0 = b1.rdata0; end
      if (b1.rvalid1 === 1'b1 && v1 < 0) begin v1 = c; d1 = b1.rdata1; end
    end
    b1.req0 = 0; b1.req1 = 0;
    n_cmp++; if (a0 != 1) begin n_err++;
      $display("FAIL cf_ack0_cycle got %0d want 1", a0); end
    n_cmp++; if (v0 != 3 || d0 !== 16'hBEEF) begin n_err++;
      $display("FAIL cf_rvalid0 got cycle %0d data %h want 3 beef", v0, d0); end
    n_cmp++; if (v0 < 0 || a1 < v0 || a1 > v0 + 1) begin n_err++;
      $display("FAIL cf_ack1_cycle got %0d want %0d or %0d", a1, v0, v0 + 1); end
    n_cmp++; if (a1 < 0 || v1 != a1 + 2 || d1 !== 16'h1234) begin n_err++;
      $display("FAIL cf_rvalid1 got cycle %0d data %h want %0d 1234", v1, d1, a1 + 2); end
    n_cmp++; if (b1.rdata0 !== 16'hBEEF) begin n_err++;
      $display("FAIL cf_rdata0_kept got %h want beef", b1.rdata0); end
  endtask

  task automatic test_sustained_writes();
    logic e0, e1;
    do_reset();
    b1.req0 = 1; b1.we0 = 1; b1.addr0 = 10'h010; b1.wdata0 = 16'h0A0A;
    b1.req1 = 1; b1.we1 = 1; b1.addr1 = 10'h020; b1.wdata1 = 16'h0B0B;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef BRAM_ARB_FIXED_PRI_EN
      e0 = (c % 2) == 1;
      e1 = 1'b0;
`else
      e0 = (c % 4) == 1;
      e1 = (c % 4) == 3;
`endif
      n_cmp++; if (b1.ack0 !== e0 || b1.ack1 !== e1) begin n_err++;
        $display("FAIL sw_acks cycle %0d got %b%b want %b%b", c, b1.ack0, b1.ack1, e0, e1); end
    end
    b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    int seen;
    do_reset();
    b1.req0 = 1; b1.we0 = 0; b1.addr0 = 10'h001;
    tick();  // k+1
    n_cmp++; if (b1.ack0 !== 1'b1) begin n_err++;
      $display("FAIL mr_ack0 got %b want 1", b1.ack0); end
    b1.req0 = 0;
    tick();  // k+2: reset sampled at the end of this cycle
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    n_cmp++; if ({b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1, b1.wea, b1.busy} !== 6'b0) begin n_err++;
      $display("FAIL mr_ctrl got %b want 000000", {b1.ack0, b1.ack1, b1.rvalid0, b1.rvalid1, b1.wea, b1.busy}); end
    n_cmp++; if ({b1.addra, b1.dina, b1.rdata0, b1.rdata1} !== 58'h0) begin n_err++;
      $display("FAIL mr_data got %h want 0", {b1.addra, b1.dina, b1.rdata0, b1.rdata1}); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (b1.rvalid0 === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++;
      $display("FAIL mr_no_rvalid got %0d pulses want 0", seen); end
    b1.req1 = 1; b1.we1 = 0; b1.addr1 = 10'h002;
    tick();
    n_cmp++; if (b1.ack1 !== 1'b1) begin n_err++;
      $display("FAIL mr_next_ack1 got %b want 1", b1.ack1); end
    b1.req1 = 0;
    tick();
    tick();
    n_cmp++; if (b1.rvalid1 !== 1'b1 || b1.rdata1 !== 16'h1234) begin n_err++;
      $display("FAIL mr_next_rd got rvalid1=%b rdata1=%h want 1 1234", b1.rvalid1, b1.rdata1); end
  endtask

  task automatic test_boundary_lat2();
    b2.req0 = 1; b2.we0 = 1; b2.addr0 = 10'h3FF; b2.wdata0 = 16'hA5A5;
    tick();
    n_cmp++; if (b2.ack0 !== 1'b1 || b2.wea !== 1'b1 || b2.addra !== 10'h3FF || b2.dina !== 16'hA5A5) begin n_err++;
      $display("FAIL bd_wr got ack0=%b wea=%b addra=%h dina=%h want 1 1 3ff a5a5", b2.ack0, b2.wea, b2.addra, b2.dina); end
    b2.req0 = 0; b2.we0 = 0;
    tick();
    tick();
    b2.req0 = 1; b2.we0 = 0; b2.addr0 = 10'h3FF;
    tick();  // k+1
    n_cmp++; if (b2.ack0 !== 1'b1 || b2.busy !== 1'b1 || b2.addra !== 10'h3FF) begin n_err++;
      $display("FAIL bd_rd_ack got ack0=%b busy=%b addra=%h want 1 1 3ff", b2.ack0, b2.busy, b2.addra); end
    b2.req0 = 0;
    tick();  // k+2
    n_cmp++; if (b2.busy !== 1'b1 || b2.rvalid0 !== 1'b0) begin n_err++;
      $display("FAIL bd_k2 got busy=%b rvalid0=%b want 1 0", b2.busy, b2.rvalid0); end
    tick();  // k+3
    n_cmp++; if (b2.busy !== 1'b1 || b2.rvalid0 !== 1'b0) begin n_err++;
      $display("FAIL bd_k3 got busy=%b rvalid0=%b want 1 0", b2.busy, b2.rvalid0); end
    tick();  // k+4
    n_cmp++; if (b2.rvalid0 !== 1'b1 || b2.rdata0 !== 16'hA5A5 || b2.busy !== 1'b0) begin n_err++;
      $display("FAIL bd_k4 got rvalid0=%b rdata0=%h busy=%b want 1 a5a5 0", b2.rvalid0, b2.rdata0, b2.busy); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_read_back();
    test_conflict();
    test_sustained_writes();
    test_reset_mid_read();
    test_boundary_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
